// File: rtl/line_toggle_grid.sv
// N x N puzzle-grid core: cell register array, row/column moves over a valid/ready
// handshake, LFSR-driven scramble FSM, saturating move counter and registered win detect.
module line_toggle_grid #(
    parameter int unsigned N              = 4,
    parameter int unsigned CELL_W         = 2,
    parameter int unsigned SCRAMBLE_MOVES = 16,
    parameter int unsigned CNT_W          = 10,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    clear_i,
    input  logic                    move_valid_i,
    output logic                    move_ready_o,
    input  logic                    move_is_col_i,
    input  logic [N-1:0]            move_sel_i,
    input  logic                    add_n_i,
    output logic [N*N*CELL_W-1:0]   cells_o,
    output logic                    busy_o,
    output logic                    win_o,
    output logic                    move_err_o,
    output logic [CNT_W-1:0]        move_count_o,
    output logic [1:0]              fsm_state_o
);

    localparam int unsigned IdxW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned RemW  = $clog2(SCRAMBLE_MOVES + 1);
    localparam int unsigned GridW = N * N * CELL_W;
    localparam logic [IdxW:0] IdxLim = (IdxW + 1)'(N);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StScramble = 2'd1,
        StPlay     = 2'd2,
        StWon      = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [GridW-1:0]   cells_q, cells_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [RemW-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;

    logic               move_fire;
    logic               legal;
    logic               uniform;
    logic [IdxW-1:0]    scr_idx;
    logic               scr_hit;
    logic               apply_en;
    logic               apply_col;
    logic               apply_inc;
    logic [N-1:0]       apply_sel;

    // Handshake, one-hot legality and LFSR decode for the scramble step
    always_comb begin
        move_ready_o = ((state_q == StIdle) || (state_q == StPlay)) && !start_i && !clear_i;
        move_fire    = move_valid_i && move_ready_o;
        legal        = (move_sel_i != '0) && ((move_sel_i & (move_sel_i - N'(1))) == '0);
        scr_idx      = lfsr_q[IdxW-1:0];
        // Indices >= N are no-op cycles when N is not a power of two
        scr_hit      = (state_q == StScramble) && ({1'b0, scr_idx} < IdxLim);
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Win detect looks at the registered grid, so WON lags the final move by one cycle
    always_comb begin
        uniform = 1'b1;
        for (int unsigned k = 1; k < N * N; k++) begin
            if (cells_q[k*CELL_W +: CELL_W] != cells_q[0 +: CELL_W]) begin
                uniform = 1'b0;
            end
        end
    end

    // Select which move (scramble or user) drives the grid this cycle
    always_comb begin
        apply_en  = 1'b0;
        apply_col = 1'b0;
        apply_inc = 1'b0;
        apply_sel = '0;
        if (scr_hit) begin
            apply_en  = 1'b1;
            apply_col = lfsr_q[15];
            apply_inc = 1'b1;
            apply_sel = N'(1) << scr_idx;
        end else if (move_fire && legal) begin
            apply_en  = 1'b1;
            apply_col = move_is_col_i;
            apply_inc = add_n_i;
            apply_sel = move_sel_i;
        end
    end

    // Grid next-state: clear wins, otherwise add or subtract one on the selected line
    always_comb begin
        cells_d = cells_q;
        if (clear_i) begin
            cells_d = '0;
        end else if (apply_en) begin
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    if (apply_col ? apply_sel[c] : apply_sel[r]) begin
                        if (apply_inc) begin
                            cells_d[(r*N+c)*CELL_W +: CELL_W] =
                                cells_q[(r*N+c)*CELL_W +: CELL_W] + CELL_W'(1);
                        end else begin
                            cells_d[(r*N+c)*CELL_W +: CELL_W] =
                                cells_q[(r*N+c)*CELL_W +: CELL_W] - CELL_W'(1);
                        end
                    end
                end
            end
        end
    end

    // FSM next-state, remaining-scramble count and saturating move counter
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        count_d = count_q;
        err_d   = move_fire && !legal;
        if (clear_i) begin
            state_d = StIdle;
            rem_d   = '0;
            count_d = '0;
        end else if (start_i && (state_q != StScramble)) begin
            state_d = StScramble;
            rem_d   = RemW'(SCRAMBLE_MOVES);
        end else begin
            case (state_q)
                StScramble: begin
                    if (scr_hit) begin
                        rem_d = rem_q - RemW'(1);
                        if (rem_q == RemW'(1)) begin
                            state_d = StPlay;
                            count_d = '0;
                        end
                    end
                end
                StPlay: begin
                    if (move_fire && legal && (count_q != '1)) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (uniform) begin
                        state_d = StWon;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers; the LFSR free-runs and is untouched by clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cells_q <= '0;
            lfsr_q  <= SEED;
            rem_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cells_q <= cells_d;
            lfsr_q  <= lfsr_d;
            rem_q   <= rem_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Registered outputs decoded from state
    always_comb begin
        cells_o      = cells_q;
        busy_o       = (state_q == StScramble);
        win_o        = (state_q == StWon);
        move_err_o   = err_q;
        move_count_o = count_q;
        fsm_state_o  = state_q;
    end

endmodule

// File: tb/tb_line_toggle_grid.sv
// Self-checking bench for line_toggle_grid: IDLE vector table, scramble vs a reference
// LFSR model, reverse replay to a win, priority/clear/reset sequences. A second instance
// with a 3-bit counter runs on the same stimulus to exercise saturation.
module tb_line_toggle_grid;

    localparam int N    = 4;
    localparam int CW   = 2;
    localparam int SM   = 16;
    localparam int GW   = N * N * CW;
    localparam int IDXW = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic          mv    = 1'b0;
    logic          mcol  = 1'b0;
    logic          add   = 1'b0;
    logic [N-1:0]  msel  = '0;

    logic [GW-1:0] cells, cells2;
    logic          ready, ready2, busy, busy2, win, win2, err, err2;
    logic [9:0]    cnt;
    logic [2:0]    cnt3;
    logic [1:0]    st, st2;

    line_toggle_grid #(.N(N), .CELL_W(CW), .SCRAMBLE_MOVES(SM), .CNT_W(10), .SEED(SEED)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear),
        .move_valid_i(mv), .move_ready_o(ready), .move_is_col_i(mcol), .move_sel_i(msel),
        .add_n_i(add), .cells_o(cells), .busy_o(busy), .win_o(win), .move_err_o(err),
        .move_count_o(cnt), .fsm_state_o(st)
    );

    line_toggle_grid #(.N(N), .CELL_W(CW), .SCRAMBLE_MOVES(SM), .CNT_W(3), .SEED(SEED)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear),
        .move_valid_i(mv), .move_ready_o(ready2), .move_is_col_i(mcol), .move_sel_i(msel),
        .add_n_i(add), .cells_o(cells2), .busy_o(busy2), .win_o(win2), .move_err_o(err2),
        .move_count_o(cnt3), .fsm_state_o(st2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model of the grid and FSM
    int          m_cell[N*N];
    logic [1:0]  m_st;
    int          m_cnt;
    int          m_rem;
    logic        m_err;
    logic [15:0] m_lfsr;
    int          scr_col[$];
    int          scr_idx[$];

    typedef struct {
        logic [GW-1:0] cells;
        logic [1:0]    st;
        int            cnt;
        logic          err;
    } exp_t;
    exp_t sb_q[$];

    function automatic logic [GW-1:0] pack_model();
        logic [GW-1:0] p;
        p = '0;
        for (int k = 0; k < N * N; k++) p[k*CW +: CW] = CW'(m_cell[k]);
        return p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N * N; k++) m_cell[k] = 0;
        m_st   = 2'd0;
        m_cnt  = 0;
        m_rem  = 0;
        m_err  = 1'b0;
        m_lfsr = SEED;
    endtask

    task automatic apply_line(input logic col, input int line, input logic inc);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if ((col ? c : r) == line)
                    m_cell[r*N+c] = (m_cell[r*N+c] + (inc ? 1 : (1 << CW) - 1)) % (1 << CW);
    endtask

    // One clock cycle: drive inputs, predict, push expectation, clock, pop and compare
    task automatic cycle(input logic v, input logic col, input logic [N-1:0] sel,
                         input logic a, input logic s, input logic c);
        logic rdy, acc, lg, uni;
        int   idx, line;
        exp_t e;
        mv = v; mcol = col; msel = sel; add = a; start = s; clear = c;
        #1;
        rdy = ((m_st == 2'd0) || (m_st == 2'd2)) && !s && !c;
        check("move_ready", ready, rdy);
        check("move_ready_sat", ready2, rdy);
        acc = v && rdy;
        lg  = ($countones(sel) == 1);
        line = 0;
        for (int i = 0; i < N; i++) if (sel[i]) line = i;
        uni = 1'b1;
        for (int k = 1; k < N * N; k++) if (m_cell[k] != m_cell[0]) uni = 1'b0;
        m_err = acc && !lg;
        if (c) begin
            for (int k = 0; k < N * N; k++) m_cell[k] = 0;
            m_st = 2'd0; m_cnt = 0; m_rem = 0;
        end else if (s && m_st != 2'd1) begin
            m_st = 2'd1; m_rem = SM;
        end else begin
            case (m_st)
                2'd1: begin
                    idx = int'(m_lfsr) % (1 << IDXW);
                    if (idx < N) begin
                        apply_line(m_lfsr[15], idx, 1'b1);
                        scr_col.push_back(int'(m_lfsr[15]));
                        scr_idx.push_back(idx);
                        m_rem--;
                        if (m_rem == 0) begin m_st = 2'd2; m_cnt = 0; end
                    end
                end
                2'd2: begin
                    if (acc && lg) begin
                        apply_line(col, line, a);
                        if (m_cnt < 1023) m_cnt++;
                    end
                    if (uni) m_st = 2'd3;
                end
                2'd0: if (acc && lg) apply_line(col, line, a);
                default: ;
            endcase
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        e.cells = pack_model(); e.st = m_st; e.cnt = m_cnt; e.err = m_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("cells", cells, e.cells);
            check("fsm_state", st, e.st);
            check("move_count", cnt, e.cnt);
            check("move_err", err, e.err);
            check("busy", busy, e.st == 2'd1);
            check("win", win, e.st == 2'd3);
            check("cells_sat", cells2, e.cells);
            check("fsm_state_sat", st2, e.st);
            check("move_count_sat", cnt3, (e.cnt > 7) ? 7 : e.cnt);
            check("busy_sat", busy2, e.st == 2'd1);
            check("win_sat", win2, e.st == 2'd3);
            check("move_err_sat", err2, e.err);
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear without an edge
    task automatic pulse_reset(input string tag);
        mv = 1'b0; start = 1'b0; clear = 1'b0; msel = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_cells"}, cells, '0);
        check({tag, "_state"}, st, 2'd0);
        check({tag, "_count"}, cnt, 0);
        check({tag, "_win"}, win, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_ready"}, ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        scr_col.delete();
        scr_idx.delete();
    endtask

    typedef struct {
        logic          col;
        logic [N-1:0]  sel;
        logic          add;
        logic [GW-1:0] exp_cells;
        logic          exp_err;
    } vec_t;
    vec_t tv[11];

    int busy_cycles;

    initial begin
        tv[0]  = '{1'b0, 4'b0010, 1'b1, 32'h0000_5500, 1'b0};
        tv[1]  = '{1'b0, 4'b0010, 1'b0, 32'h0000_0000, 1'b0};
        tv[2]  = '{1'b1, 4'b1000, 1'b1, 32'h4040_4040, 1'b0};
        tv[3]  = '{1'b1, 4'b1000, 1'b1, 32'h8080_8080, 1'b0};
        tv[4]  = '{1'b1, 4'b1000, 1'b1, 32'hC0C0_C0C0, 1'b0};
        tv[5]  = '{1'b1, 4'b1000, 1'b1, 32'h0000_0000, 1'b0};
        tv[6]  = '{1'b0, 4'b0110, 1'b1, 32'h0000_0000, 1'b1};
        tv[7]  = '{1'b0, 4'b0000, 1'b1, 32'h0000_0000, 1'b1};
        tv[8]  = '{1'b1, 4'b0001, 1'b0, 32'h0303_0303, 1'b0};
        tv[9]  = '{1'b0, 4'b1000, 1'b1, 32'h5403_0303, 1'b0};
        tv[10] = '{1'b1, 4'b1100, 1'b0, 32'h5403_0303, 1'b1};

        model_reset();
        #1;
        check("por_cells", cells, '0);
        check("por_state", st, 2'd0);
        check("por_ready", ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // IDLE move table
        for (int i = 0; i < 11; i++) begin
            cycle(1'b1, tv[i].col, tv[i].sel, tv[i].add, 1'b0, 1'b0);
            check($sformatf("vec%0d_cells", i), cells, tv[i].exp_cells);
            check($sformatf("vec%0d_err", i), err, tv[i].exp_err);
            check($sformatf("vec%0d_count", i), cnt, 0);
            idle();
            check($sformatf("vec%0d_err_drop", i), err, 0);
        end

        pulse_reset("rst_midrun");

        // Start with a concurrent move: move dropped, scramble entered
        busy_cycles = 0;
        cycle(1'b1, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0);
        check("start_move_dropped", cells, '0);
        if (busy) busy_cycles++;
        for (int k = 0; k < 200 && m_st == 2'd1; k++) begin
            idle();
            if (busy) busy_cycles++;
        end
        check("scramble_timeout", m_st == 2'd1, 0);
        check("scramble_busy_cycles", busy_cycles, SM);
        check("scramble_end_state", st, 2'd2);
        check("scramble_end_count", cnt, 0);

        // Undo the scramble with decrements in reverse order
        for (int i = scr_idx.size() - 1; i >= 0; i--) begin
            cycle(1'b1, scr_col[i][0], N'(1) << scr_idx[i], 1'b0, 1'b0, 1'b0);
        end
        idle();
        idle();
        check("won_win", win, 1);
        check("won_ready", ready, 0);
        cycle(1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
        check("won_frozen", cells, '0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("clear_to_idle", st, 2'd0);

        // Start ignored mid-scramble, then clear beats start
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(); idle(); idle();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(); idle();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("clear_start_state", st, 2'd0);
        check("clear_start_cells", cells, '0);

        // Reset during a scramble aborts it
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(); idle();
        pulse_reset("rst_scramble");
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
